adbg_cpu_arbiter: RTL and testbench

ADBG_CPU_ARBITER -- requirements
Module: adbg_cpu_arbiter

---
 rtl/adbg_arb_pkg.sv | 22 ++
 rtl/adbg_rr_picker.sv | 34 +++
 rtl/adbg_cpu_arbiter.sv | 115 +++++++++++
 tb/tb_adbg_cpu_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_arb_pkg.sv
// Shared types and constants for the debug-bus CPU arbiter.
package adbg_arb_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Bus wait, in cycles, before a transfer is aborted with an error.
    localparam int DEFAULT_TIMEOUT = 255;

    // Largest requester count the 4-bit select output can address.
    localparam int MAX_CORES = 16;

    // Width of a requester index; at least one bit even for a single core.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adbg_rr_picker.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
module adbg_rr_picker
    import adbg_arb_pkg::*;
#(
    parameter int NB_CORES = 4,
    localparam int IW = idx_width(NB_CORES)
) (
    input  logic [NB_CORES-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic                valid,
    output logic [IW-1:0]       idx
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int cand;
        logic [IW-1:0] cand_idx;
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NB_CORES; off >= 1; off--) begin
            // ptr < NB_CORES and off <= NB_CORES, so one subtraction wraps.
            cand = int'(ptr) + off;
            if (cand >= NB_CORES) cand = cand - NB_CORES;
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/adbg_cpu_arbiter.sv
// Arbitrates NB_CORES SPR requesters onto one shared debug bus.
// One transfer at a time: IDLE picks, BUSY drives the bus, RESP acks.
module adbg_cpu_arbiter
    import adbg_arb_pkg::*;
#(
    parameter int NB_CORES       = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                      cpu_clk_i,
    input  logic                      cpu_rst_i,
    input  logic [NB_CORES-1:0]       req_stb_i,
    input  logic [NB_CORES-1:0]       req_we_i,
    input  logic [NB_CORES-1:0][15:0] req_addr_i,
    input  logic [NB_CORES-1:0][31:0] req_data_i,
    output logic [NB_CORES-1:0]       req_ack_o,
    output logic [NB_CORES-1:0]       req_err_o,
    output logic [31:0]               req_data_o,
    output logic                      bus_stb_o,
    output logic                      bus_we_o,
    output logic [15:0]               bus_addr_o,
    output logic [31:0]               bus_data_o,
    output logic [3:0]                bus_sel_o,
    input  logic [31:0]               bus_data_i,
    input  logic                      bus_ack_i
);

    localparam int          IW       = idx_width(NB_CORES);
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [15:0]   count;
    logic          err_flag;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    adbg_rr_picker #(
        .NB_CORES (NB_CORES)
    ) u_picker (
        .req   (req_stb_i),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Transaction FSM; every output is a register so the bus sees clean levels.
    // The completion pulse is loaded on entry to RESP so it is visible exactly
    // during the RESP cycle, and the requester's strobe is already low when
    // IDLE samples again.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state      <= ST_IDLE;
            rr_ptr     <= IW'(NB_CORES - 1);
            grant      <= '0;
            count      <= '0;
            err_flag   <= 1'b0;
            req_ack_o  <= '0;
            req_err_o  <= '0;
            req_data_o <= '0;
            bus_stb_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= '0;
            bus_data_o <= '0;
            bus_sel_o  <= '0;
        end else begin
            req_ack_o <= '0;
            req_err_o <= '0;
            case (state)
                ST_IDLE: begin
                    // Only the winner's fields are captured.
                    if (pick_vld) begin
                        grant      <= pick_idx;
                        bus_we_o   <= req_we_i[pick_idx];
                        bus_addr_o <= req_addr_i[pick_idx];
                        bus_data_o <= req_data_i[pick_idx];
                        bus_sel_o  <= 4'(pick_idx);
                        bus_stb_o  <= 1'b1;
                        count      <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack in the last allowed cycle still counts as success.
                    if (bus_ack_i) begin
                        req_data_o       <= bus_data_i;
                        err_flag         <= 1'b0;
                        req_ack_o[grant] <= 1'b1;
                        bus_stb_o        <= 1'b0;
                        state            <= ST_RESP;
                    end else if (count == LAST_CNT) begin
                        req_data_o       <= '0;
                        err_flag         <= 1'b1;
                        req_ack_o[grant] <= 1'b1;
                        req_err_o[grant] <= 1'b1;
                        bus_stb_o        <= 1'b0;
                        state            <= ST_RESP;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                ST_RESP: begin
                    // The next search starts just past the core served now.
                    rr_ptr <= grant;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adbg_cpu_arbiter.sv
// Self-checking bench for adbg_cpu_arbiter (4 cores, 8-cycle timeout).
module tb_adbg_cpu_arbiter;

    localparam int NC  = 4;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NC-1:0]       req_stb = '0;
    logic [NC-1:0]       req_we = '0;
    logic [NC-1:0][15:0] req_addr = '0;
    logic [NC-1:0][31:0] req_data = '0;
    logic [NC-1:0]       req_ack;
    logic [NC-1:0]       req_err;
    logic [31:0]         req_rdata;
    logic                bus_stb;
    logic                bus_we;
    logic [15:0]         bus_addr;
    logic [31:0]         bus_wdata;
    logic [3:0]          bus_sel;
    logic [31:0]         bus_rdata = '0;
    logic                bus_ack = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;
    int m_ptr   = NC - 1;

    adbg_cpu_arbiter #(
        .NB_CORES       (NC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .cpu_clk_i  (clk),
        .cpu_rst_i  (rst),
        .req_stb_i  (req_stb),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_ack_o  (req_ack),
        .req_err_o  (req_err),
        .req_data_o (req_rdata),
        .bus_stb_o  (bus_stb),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_data_o (bus_wdata),
        .bus_sel_o  (bus_sel),
        .bus_data_i (bus_rdata),
        .bus_ack_i  (bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  stb;
        int          dly;
        logic [31:0] rdata;
        int          g;
        logic        e;
        logic [31:0] d;
        int          cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_stb"},   32'(bus_stb),   32'h0);
        chk({tag, "_we"},    32'(bus_we),    32'h0);
        chk({tag, "_addr"},  32'(bus_addr),  32'h0);
        chk({tag, "_wdata"}, bus_wdata,      32'h0);
        chk({tag, "_sel"},   32'(bus_sel),   32'h0);
        chk({tag, "_ack"},   32'(req_ack),   32'h0);
        chk({tag, "_err"},   32'(req_err),   32'h0);
        chk({tag, "_rdata"}, req_rdata,      32'h0);
    endtask

    // Round-robin rule: first set strobe strictly after the last grant.
    function automatic int model_pick(input logic [3:0] stb, input int ptr);
        int g;
        bit found;
        g = 0;
        found = 0;
        for (int o = 1; o <= NC; o++) begin
            if (!found && stb[(ptr + o) % NC]) begin
                g = (ptr + o) % NC;
                found = 1;
            end
        end
        return g;
    endfunction

    // One full transfer. Entered and left at a negedge of an IDLE cycle.
    // The bus acks at the end of BUSY cycle number dly (0-based).
    task automatic run_txn(input logic [3:0] stb, input int dly, input logic [31:0] rd,
                           input int eg, input logic ee, input logic [31:0] ed, input int ec);
        logic        x_we;
        logic [15:0] x_addr;
        logic [31:0] x_data;
        int n, k;
        x_we   = req_we[eg];
        x_addr = req_addr[eg];
        x_data = req_data[eg];
        bus_ack = 1'b0;
        req_stb = stb;
        @(negedge clk);
        n = 0;
        while (bus_stb !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("grant_latency", 32'(n), 32'h0);
        k = 0;
        while (bus_stb === 1'b1 && k < 20) begin
            chk("bus_sel",   32'(bus_sel),  32'(eg));
            chk("bus_we",    32'(bus_we),   32'(x_we));
            chk("bus_addr",  32'(bus_addr), 32'(x_addr));
            chk("bus_wdata", bus_wdata,     x_data);
            chk("no_ack_in_busy", 32'(req_ack), 32'h0);
            // Requester-side inputs may wander during BUSY; they must not leak.
            for (int c = 0; c < NC; c++) begin
                req_addr[c] = 16'($urandom);
                req_data[c] = $urandom;
                req_we[c]   = 1'($urandom_range(0, 1));
            end
            bus_ack   = (k == dly);
            bus_rdata = (k == dly) ? rd : $urandom;
            @(negedge clk);
            k++;
        end
        chk("busy_cycles", 32'(k), 32'(ec));
        chk("resp_ack",   32'(req_ack), 32'(1 << eg));
        chk("resp_err",   32'(req_err), ee ? 32'(1 << eg) : 32'h0);
        chk("resp_rdata", req_rdata, ed);
        // bus_ack stays as driven through RESP; it must be ignored there.
        req_stb[eg] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(req_ack), 32'h0);
        chk("err_one_cycle", 32'(req_err), 32'h0);
        chk("rdata_hold",    req_rdata, ed);
        bus_ack = 1'b0;
        m_ptr = eg;
    endtask

    task automatic do_reset();
        req_stb = '0;
        bus_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero_outs("reset");
        rst = 1'b0;
        m_ptr = NC - 1;
    endtask

    task automatic load_fixed_cores();
        req_we      = 4'b1010;
        req_addr[0] = 16'h0100;
        req_addr[1] = 16'h0010;
        req_addr[2] = 16'h1234;
        req_addr[3] = 16'h0300;
        req_data[0] = 32'h1111_1111;
        req_data[1] = 32'hA5A5_A5A5;
        req_data[2] = 32'h2222_2222;
        req_data[3] = 32'h3333_3333;
    endtask

    initial begin
        vec_t tbl[7];
        logic [3:0]  stb;
        logic [31:0] rd;
        int dly, g, ec;
        logic ee;

        // Sequence starts right after reset, pointer at core 3.
        tbl[0] = '{4'b0100, 1, 32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D, 2}; // core 2 read 0x1234
        tbl[1] = '{4'b1111, 0, 32'h1357_2468, 3, 1'b0, 32'h1357_2468, 1};
        tbl[2] = '{4'b0011, 9, 32'hDEAD_DEAD, 0, 1'b1, 32'h0000_0000, 8}; // timeout
        tbl[3] = '{4'b0011, 7, 32'h0BAD_BEEF, 1, 1'b0, 32'h0BAD_BEEF, 8}; // ack on 8th cycle; core 1 write
        tbl[4] = '{4'b0001, 2, 32'h4444_0000, 0, 1'b0, 32'h4444_0000, 3};
        tbl[5] = '{4'b1001, 0, 32'h5555_0001, 3, 1'b0, 32'h5555_0001, 1};
        tbl[6] = '{4'b0001, 5, 32'h6666_0002, 0, 1'b0, 32'h6666_0002, 6};

        load_fixed_cores();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            load_fixed_cores();
            run_txn(tbl[i].stb, tbl[i].dly, tbl[i].rdata, tbl[i].g, tbl[i].e, tbl[i].d, tbl[i].cyc);
        end

        // All four requesters keep strobing: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_fixed_cores();
            run_txn(4'b1111, 0, 32'h7000_0000 + 32'(i), i % NC, 1'b0, 32'h7000_0000 + 32'(i), 1);
        end

        // Reset in the middle of a transfer: strobe drops at once, no ack.
        load_fixed_cores();
        req_stb = 4'b0100;
        @(negedge clk);
        chk("midrst_busy", 32'(bus_stb), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_zero_outs("midrst_async");
        req_stb = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(req_ack), 32'h0);
        end
        rst = 1'b0;
        m_ptr = NC - 1;
        run_txn(4'b1111, 1, 32'h8888_8888, 0, 1'b0, 32'h8888_8888, 2);

        // Random traffic against the transaction-level model.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NC; c++) begin
                req_we[c]   = 1'($urandom_range(0, 1));
                req_addr[c] = 16'($urandom);
                req_data[c] = $urandom;
            end
            stb = 4'($urandom_range(1, 15));
            dly = $urandom_range(0, 10);
            rd  = $urandom;
            g   = model_pick(stb, m_ptr);
            ee  = (dly + 1 > TMO);
            ec  = ee ? TMO : dly + 1;
            run_txn(stb, dly, rd, g, ee, ee ? 32'h0 : rd, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
